sdhci_cmd_ctrl: RTL and testbench
=================================

Name: sdhci_cmd_ctrl

Overview:
- Command-line (CMD) sequencer of the SD host controller.
- Accepts a command request from the register logic (index, argument, response type) and serialises the 48-bit command frame onto CMD, generating CRC7 on the fly.
- Captures and checks the 48- or 136-bit response, or flags a timeout.
- Runs entirely in clk_i and is paced by single-cycle SD-clock edge strobes from the SD clock divider.

Parameters:
- RespTimeout, 64, number of sd_clk rising strobes to wait for a response start bit before a timeout error (Ncr limit).
- TimeoutWidth, 8, width of the timeout counter; RespTimeout must be below 2**TimeoutWidth.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- sd_clk_rise_i  in  1  one-cycle strobe marking an sd_clk rising edge (sample point).
- sd_clk_fall_i  in  1  one-cycle strobe marking an sd_clk falling edge (drive point).
- start_i  in  1  command request pulse; accepted only when busy_o=0.
- abort_i  in  1  synchronous abort (software reset CMD line).
- cmd_index_i  in  6  command index, sampled on accepted start_i.
- cmd_arg_i  in  32  command argument, sampled on accepted start_i.
- resp_type_i  in  2  response type, sampled on accepted start_i: 00 none, 01 136-bit, 10 48-bit, 11 48-bit (busy wait is not handled here).
- crc_check_en_i  in  1  enables the response CRC7 check, sampled on start.
- index_check_en_i  in  1  enables the response index check, sampled on start.
- cmd_i  in  1  CMD line input (pad).
- cmd_o  out  1  CMD line output value.
- cmd_oe_o  out  1  CMD output enable.
- busy_o  out  1  command in progress; drives Command Inhibit (CMD).
- done_o  out  1  one-cycle pulse at command completion (with or without error).
- resp_o  out  120  response payload; 48-bit response in [31:0] (bits 39:8), upper bits 0; 136-bit response in [119:0] (bits 127:8).
- timeout_err_o  out  1  valid with done_o.
- crc_err_o  out  1  valid with done_o.
- end_bit_err_o  out  1  valid with done_o.
- index_err_o  out  1  valid with done_o.

Behaviour:
- Reset values: cmd_o=1, cmd_oe_o=0, busy_o=0, done_o=0, all err_o=0, resp_o=0, state IDLE.
- States: IDLE, TX, WAIT_RESP, RX, DONE.
- IDLE:
  - start_i loads a 48-bit shift register {0,1,cmd_index,cmd_arg,7'b0,1}, clears the CRC7 register and latches the configuration.
  - busy_o=1 from the next cycle. Go to TX.
  - start_i while busy_o=1 is ignored.
- TX:
  - Each sd_clk_fall_i drives the next bit MSB-first on cmd_o with cmd_oe_o=1.
  - Bits 47..8 are fed into CRC7 (x^7+x^3+1, init 0). Bits 7..1 drive the CRC register MSB-first; bit 0 drives 1.
  - On the fall strobe after the end bit: cmd_oe_o=0, cmd_o=1.
  - Then go to WAIT_RESP, or to DONE if resp_type=00.
- WAIT_RESP:
  - Each sd_clk_rise_i samples cmd_i. A 0 starts the frame: go to RX with bit counter=1.
  - Otherwise the timeout counter increments. When it reaches RespTimeout: timeout_err, go to DONE.
- RX:
  - Shift in on each rise strobe until 48 (types 10/11) or 136 (type 01) bits total, start bit included.
  - CRC7 covers bits 47..8 for 48-bit frames and bits 127..8 for 136-bit frames.
  - The received bits 7..1 are compared with the computed CRC.
  - After the last bit go to DONE.
- DONE, one cycle:
  - done_o=1 and resp_o updated; busy_o falls in the same cycle. Return to IDLE.
  - crc_err when enabled and the CRC mismatches.
  - end_bit_err when the last bit is 0.
  - index_err only for 48-bit frames, when enabled and bits 45:40 differ from cmd_index.
  - On timeout, resp_o holds its previous value.
  - Error outputs hold their value until the next accepted start_i clears them.
- Strobe priority: rise and fall strobes are mutually exclusive by construction. If both are asserted, the fall strobe is ignored.
- Strobe-free cycles: no state progress.
- abort_i: from any state, next cycle returns to IDLE with cmd_oe_o=0, cmd_o=1 and busy_o=0. No done_o. Errors and resp_o are unchanged. abort_i takes priority over start_i.
- Asynchronous reset mid-frame immediately restores the reset values.

Test Plan:
- CMD0 (idx 0, arg 0, type 00): cmd_o sequence over 48 fall strobes is 0x400000000095. cmd_oe_o is 1 only during those 48 bits. done_o fires one cycle after release with no errors.
- CMD8 (arg 0x1AA, type 10): transmits 0x48000001AA87. Responder drives 0x08000001AA13 after 5 rise strobes. Expect done_o, resp_o[31:0]=0x000001AA, no errors.
- Timeout: CMD17 (arg 0) transmits 0x510000000055, and cmd_i is held at 1. Expect done_o with timeout_err_o=1 exactly 64 rise strobes after the release.
- Response errors:
  - CMD8 response with one argument bit flipped gives crc_err_o=1.
  - Response with index 9 gives index_err_o=1, and 0 when index_check_en_i=0.
  - Response with end bit 0 gives end_bit_err_o=1.
- R2 (type 01): 136-bit response with a valid CRC. resp_o equals the received bits 127:8, index_err_o=0, and busy_o stays high for the full 136 strobes.
- Abort and reentry:
  - abort_i at TX bit 20 gives cmd_oe_o=0 and busy_o=0 the next cycle, with no done_o.
  - A new start_i then transmits cleanly.
  - start_i while busy is ignored.

Source files
------------

// File: rtl/sdhci_cmd_ctrl.sv
// SD CMD-line sequencer: sends a 48-bit command frame with CRC7 and captures or checks the 48/136-bit response.
// The command is accepted one cycle after start_i. Progress is paced only by the sd_clk rise/fall strobes.
// start_i is ignored while busy_o=1. abort_i returns the sequencer to idle on the next cycle.
module sdhci_cmd_ctrl #(
    parameter int unsigned RespTimeout  = 64,
    parameter int unsigned TimeoutWidth = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         sd_clk_rise_i,
    input  logic         sd_clk_fall_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   resp_type_i,
    input  logic         crc_check_en_i,
    input  logic         index_check_en_i,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_oe_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [119:0] resp_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         end_bit_err_o,
    output logic         index_err_o
);
    typedef enum logic [2:0] {IDLE, TX, WAIT_RESP, RX, DONE} state_t;

    localparam logic [TimeoutWidth-1:0] ToutLast = TimeoutWidth'(RespTimeout - 1);

    state_t                  state;
    logic [47:0]             tx_sh;
    logic [127:0]            rx_sh;
    logic [6:0]              crc;
    logic [7:0]              bit_cnt;
    logic [TimeoutWidth-1:0] tout_cnt;
    logic                    tout_hit;
    logic [5:0]              idx_q;
    logic [1:0]              type_q;
    logic                    crc_en_q;
    logic                    idx_en_q;

    logic       rise;
    logic       fall;
    logic       is_long;
    logic       crc_win;
    logic [7:0] frame_len;

    assign rise      = sd_clk_rise_i;
    assign fall      = sd_clk_fall_i & ~sd_clk_rise_i;
    assign is_long   = (type_q == 2'b01);
    assign frame_len = is_long ? 8'd136 : 8'd48;
    // The start bit of a 48-bit frame is a 0 entering an all-zero CRC, so it is not fed in.
    assign crc_win   = (bit_cnt <= frame_len - 8'd9) && (!is_long || bit_cnt >= 8'd8);

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            tx_sh         <= '0;
            rx_sh         <= '0;
            crc           <= '0;
            bit_cnt       <= '0;
            tout_cnt      <= '0;
            tout_hit      <= 1'b0;
            idx_q         <= '0;
            type_q        <= '0;
            crc_en_q      <= 1'b0;
            idx_en_q      <= 1'b0;
            cmd_o         <= 1'b1;
            cmd_oe_o      <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            resp_o        <= '0;
            timeout_err_o <= 1'b0;
            crc_err_o     <= 1'b0;
            end_bit_err_o <= 1'b0;
            index_err_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state    <= IDLE;
                cmd_oe_o <= 1'b0;
                cmd_o    <= 1'b1;
                busy_o   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            tx_sh         <= {2'b01, cmd_index_i, cmd_arg_i, 7'b0, 1'b1};
                            crc           <= '0;
                            bit_cnt       <= '0;
                            tout_hit      <= 1'b0;
                            idx_q         <= cmd_index_i;
                            type_q        <= resp_type_i;
                            crc_en_q      <= crc_check_en_i;
                            idx_en_q      <= index_check_en_i;
                            busy_o        <= 1'b1;
                            timeout_err_o <= 1'b0;
                            crc_err_o     <= 1'b0;
                            end_bit_err_o <= 1'b0;
                            index_err_o   <= 1'b0;
                            state         <= TX;
                        end
                    end
                    TX: begin
                        if (fall) begin
                            if (bit_cnt == 8'd48) begin
                                cmd_oe_o <= 1'b0;
                                cmd_o    <= 1'b1;
                                crc      <= '0;
                                bit_cnt  <= '0;
                                tout_cnt <= '0;
                                state    <= (type_q == 2'b00) ? DONE : WAIT_RESP;
                            end else begin
                                cmd_oe_o <= 1'b1;
                                bit_cnt  <= bit_cnt + 8'd1;
                                if (bit_cnt < 8'd40) begin
                                    cmd_o <= tx_sh[47];
                                    crc   <= crc7_step(crc, tx_sh[47]);
                                    tx_sh <= {tx_sh[46:0], 1'b0};
                                end else if (bit_cnt < 8'd47) begin
                                    cmd_o <= crc[6];
                                    crc   <= {crc[5:0], 1'b0};
                                end else begin
                                    cmd_o <= 1'b1;
                                end
                            end
                        end
                    end
                    WAIT_RESP: begin
                        if (rise) begin
                            if (!cmd_i) begin
                                rx_sh   <= {rx_sh[126:0], 1'b0};
                                bit_cnt <= 8'd1;
                                state   <= RX;
                            end else if (tout_cnt == ToutLast) begin
                                tout_hit <= 1'b1;
                                state    <= DONE;
                            end else begin
                                tout_cnt <= tout_cnt + 1'b1;
                            end
                        end
                    end
                    RX: begin
                        if (rise) begin
                            rx_sh   <= {rx_sh[126:0], cmd_i};
                            bit_cnt <= bit_cnt + 8'd1;
                            if (crc_win) crc <= crc7_step(crc, cmd_i);
                            if (bit_cnt == frame_len - 8'd1) state <= DONE;
                        end
                    end
                    DONE: begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                        if (tout_hit) begin
                            timeout_err_o <= 1'b1;
                        end else if (type_q != 2'b00) begin
                            resp_o        <= is_long ? rx_sh[127:8] : {88'b0, rx_sh[39:8]};
                            crc_err_o     <= crc_en_q && (crc != rx_sh[7:1]);
                            end_bit_err_o <= ~rx_sh[0];
                            index_err_o   <= !is_long && idx_en_q && (rx_sh[45:40] != idx_q);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sdhci_cmd_ctrl.sv
// Bench for sdhci_cmd_ctrl: random strobe spacing, a card responder model and frame-level expected results.
module tb_sdhci_cmd_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         sd_clk_rise_i = 1'b0, sd_clk_fall_i = 1'b0;
    logic         start_i = 1'b0, abort_i = 1'b0;
    logic [5:0]   cmd_index_i = '0;
    logic [31:0]  cmd_arg_i = '0;
    logic [1:0]   resp_type_i = '0;
    logic         crc_check_en_i = 1'b0, index_check_en_i = 1'b0;
    logic         cmd_i = 1'b1;
    logic         cmd_o, cmd_oe_o, busy_o, done_o;
    logic [119:0] resp_o;
    logic         timeout_err_o, crc_err_o, end_bit_err_o, index_err_o;

    always #5 clk_i = ~clk_i;

    sdhci_cmd_ctrl dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .sd_clk_rise_i(sd_clk_rise_i), .sd_clk_fall_i(sd_clk_fall_i),
        .start_i(start_i), .abort_i(abort_i),
        .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i), .resp_type_i(resp_type_i),
        .crc_check_en_i(crc_check_en_i), .index_check_en_i(index_check_en_i),
        .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe_o(cmd_oe_o), .busy_o(busy_o), .done_o(done_o),
        .resp_o(resp_o), .timeout_err_o(timeout_err_o), .crc_err_o(crc_err_o),
        .end_bit_err_o(end_bit_err_o), .index_err_o(index_err_o)
    );

    int n_tot = 0, n_bad = 0;
    int gap = 1;
    bit nxt_rise = 1'b1, last_rise, last_fall;
    bit resp_armed = 1'b0;
    int resp_rises = 0, resp_delay = 0;
    bit resp_q[$];
    logic [119:0] exp_resp = '0;
    logic [3:0]   exp_errs = '0;
    logic [47:0]  tx;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] crc7_of(input logic [127:0] d, input int n);
        logic [6:0] c;
        logic fb;
        c = 7'd0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // One clock: record the strobes just consumed, then drive the next strobe pattern and card bit.
    task automatic step();
        @(negedge clk_i);
        last_rise = sd_clk_rise_i;
        last_fall = sd_clk_fall_i;
        sd_clk_rise_i = 1'b0;
        sd_clk_fall_i = 1'b0;
        if (gap > 0) gap--;
        else begin
            if (nxt_rise) begin
                sd_clk_rise_i = 1'b1;
                if (resp_armed && resp_rises >= resp_delay && resp_q.size() > 0) cmd_i = resp_q.pop_front();
                else cmd_i = 1'b1;
                if (resp_armed) resp_rises++;
            end else sd_clk_fall_i = 1'b1;
            nxt_rise = !nxt_rise;
            gap = $urandom_range(1, 3);
        end
    endtask

    // mode: 0 good response, 1 flipped payload bit, 2 response index ridx, 3 end bit 0, 4 card silent
    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [1:0] rt, input bit c_en, input bit i_en, input int mode,
                           input logic [5:0] ridx, input int delay, input int abort_at, input bit poke,
                           output logic [47:0] tx_seen);
        logic [47:0]  exp_tx, txv;
        logic [135:0] rf;
        logic [127:0] rnd;
        logic [119:0] body, resp_next, got_resp;
        logic [3:0]   exp_err, got_err;
        bit is_long, released, oe_viol, busy_drop, done_seen, poked, busy_at_done, any_done;
        int nbits, tx_n, rises, rel_cyc, done_cyc, k;

        exp_tx = {2'b01, idx, arg, crc7_of({88'b0, 2'b01, idx, arg}, 40), 1'b1};
        is_long = (rt == 2'b01);
        if (is_long) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            body = rnd[119:0];
            rf = {8'h3F, body, crc7_of({8'h00, body}, 120), 1'b1};
            nbits = 136;
        end else begin
            rf = {88'b0, 2'b00, ridx, arg, crc7_of({88'b0, 2'b00, ridx, arg}, 40), 1'b1};
            nbits = 48;
        end
        if (mode == 1) begin
            k = $urandom_range(0, is_long ? 119 : 31);
            rf[8 + k] = ~rf[8 + k];
        end
        if (mode == 3) rf[0] = 1'b0;
        resp_q.delete();
        if (mode != 4) for (int i = nbits - 1; i >= 0; i--) resp_q.push_back(rf[i]);
        resp_delay = delay;
        resp_rises = 0;
        resp_armed = 1'b0;

        if (rt == 2'b00) exp_err = 4'b0000;
        else if (mode == 4) exp_err = 4'b1000;
        else exp_err = {1'b0, (mode == 1) && c_en, mode == 3, !is_long && i_en && (ridx != idx)};
        if (rt == 2'b00 || mode == 4) resp_next = exp_resp;
        else resp_next = is_long ? rf[127:8] : {88'b0, rf[39:8]};

        step();
        cmd_index_i = idx; cmd_arg_i = arg; resp_type_i = rt;
        crc_check_en_i = c_en; index_check_en_i = i_en;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk({tag, ":busy_up"}, 128'(busy_o), 128'd1);
        cmd_index_i = 6'($urandom); cmd_arg_i = $urandom; resp_type_i = 2'($urandom);
        crc_check_en_i = 1'($urandom); index_check_en_i = 1'($urandom);

        txv = '0; tx_n = 0; released = 0; oe_viol = 0; busy_drop = 0; done_seen = 0;
        rises = 0; rel_cyc = 0; done_cyc = 0; poked = 0; busy_at_done = 1; got_err = '0; got_resp = '0;
        for (int c = 0; c < 4000 && !done_seen; c++) begin
            step();
            if (last_fall && !released) begin
                if (cmd_oe_o) begin
                    txv = {txv[46:0], cmd_o};
                    tx_n++;
                end else if (tx_n > 0) begin
                    released = 1; rel_cyc = c; resp_armed = (rt != 2'b00);
                end
            end
            if (released && last_rise) rises++;
            if (cmd_oe_o && (released || tx_n == 0)) oe_viol = 1;
            if (done_o) begin
                done_seen = 1; done_cyc = c; busy_at_done = busy_o; got_resp = resp_o;
                got_err = {timeout_err_o, crc_err_o, end_bit_err_o, index_err_o};
            end else if (!busy_o) busy_drop = 1;
            if (poke && tx_n == 10 && !poked) begin
                start_i = 1'b1; poked = 1; cmd_index_i = ~idx;
            end else start_i = 1'b0;
            if (abort_at >= 0 && tx_n == abort_at) begin
                abort_i = 1'b1;
                step();
                abort_i = 1'b0;
                chk({tag, ":abort_oe"}, 128'(cmd_oe_o), 128'd0);
                chk({tag, ":abort_busy"}, 128'(busy_o), 128'd0);
                chk({tag, ":abort_cmd"}, 128'(cmd_o), 128'd1);
                any_done = 0;
                for (int j = 0; j < 30; j++) begin
                    step();
                    if (done_o || busy_o || cmd_oe_o) any_done = 1;
                end
                chk({tag, ":abort_quiet"}, 128'(any_done), 128'd0);
                chk({tag, ":abort_resp"}, 128'(resp_o), 128'(exp_resp));
                chk({tag, ":abort_errs"}, 128'({timeout_err_o, crc_err_o, end_bit_err_o, index_err_o}),
                    128'(exp_errs));
                tx_seen = txv;
                return;
            end
        end
        start_i = 1'b0;
        resp_armed = 1'b0;
        tx_seen = txv;

        chk({tag, ":done"}, 128'(done_seen), 128'd1);
        chk({tag, ":tx_frame"}, 128'(txv), 128'(exp_tx));
        chk({tag, ":tx_bits"}, 128'(tx_n), 128'd48);
        chk({tag, ":oe_window"}, 128'(oe_viol), 128'd0);
        chk({tag, ":busy_held"}, 128'(busy_drop), 128'd0);
        chk({tag, ":busy_at_done"}, 128'(busy_at_done), 128'd0);
        if (rt == 2'b00) chk({tag, ":done_lat"}, 128'(done_cyc - rel_cyc), 128'd1);
        if (rt != 2'b00 && mode == 4) chk({tag, ":tout_rises"}, 128'(rises), 128'd64);
        chk({tag, ":errs"}, 128'(got_err), 128'(exp_err));
        chk({tag, ":resp"}, 128'(got_resp), 128'(resp_next));
        exp_resp = resp_next;
        exp_errs = exp_err;
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_cmd_o", 128'(cmd_o), 128'd1);
        chk("rst_oe", 128'(cmd_oe_o), 128'd0);
        chk("rst_busy", 128'(busy_o), 128'd0);
        chk("rst_done", 128'(done_o), 128'd0);
        chk("rst_resp", 128'(resp_o), 128'd0);
        chk("rst_errs", 128'({timeout_err_o, crc_err_o, end_bit_err_o, index_err_o}), 128'd0);
        rst_ni = 1'b1;

        run_cmd("cmd0", 6'd0, 32'h0, 2'b00, 1, 1, 0, 6'd0, 0, -1, 0, tx);
        chk("cmd0_vec", 128'(tx), 128'(48'h400000000095));
        run_cmd("cmd8", 6'd8, 32'h1AA, 2'b10, 1, 1, 0, 6'd8, 5, -1, 0, tx);
        chk("cmd8_vec", 128'(tx), 128'(48'h48000001AA87));
        chk("cmd8_resp", 128'(resp_o), 128'h1AA);
        run_cmd("cmd17_tout", 6'd17, 32'h0, 2'b10, 1, 1, 4, 6'd17, 0, -1, 0, tx);
        chk("cmd17_vec", 128'(tx), 128'(48'h510000000055));
        run_cmd("crc_flip", 6'd8, 32'h1AA, 2'b10, 1, 1, 1, 6'd8, 3, -1, 0, tx);
        run_cmd("idx9_on", 6'd8, 32'h1AA, 2'b10, 1, 1, 2, 6'd9, 2, -1, 0, tx);
        run_cmd("idx9_off", 6'd8, 32'h1AA, 2'b10, 1, 0, 2, 6'd9, 2, -1, 0, tx);
        run_cmd("end_bit", 6'd8, 32'h1AA, 2'b11, 1, 1, 3, 6'd8, 1, -1, 0, tx);
        run_cmd("r2", 6'd2, 32'h0, 2'b01, 1, 1, 0, 6'd0, 4, -1, 0, tx);
        run_cmd("abort", 6'd8, 32'h1AA, 2'b10, 1, 1, 0, 6'd8, 2, 20, 0, tx);
        run_cmd("reentry", 6'd0, 32'h0, 2'b00, 1, 1, 0, 6'd0, 0, -1, 0, tx);
        chk("reentry_vec", 128'(tx), 128'(48'h400000000095));
        run_cmd("poke", 6'd17, 32'h1234_5678, 2'b10, 1, 1, 0, 6'd17, 3, -1, 1, tx);

        for (int n = 0; n < 12; n++) begin
            logic [5:0] ri;
            int md;
            ri = 6'($urandom);
            md = $urandom_range(0, 4);
            run_cmd($sformatf("rnd%0d", n), ri, $urandom, 2'($urandom), 1'($urandom), 1'($urandom),
                    md, (md == 2) ? ri ^ 6'h01 : ri, $urandom_range(0, 8), -1, 0, tx);
        end

        // Asynchronous reset in the middle of a transmitted frame.
        step();
        cmd_index_i = 6'd5; cmd_arg_i = 32'hDEAD_BEEF; resp_type_i = 2'b10; start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (40) step();
        rst_ni = 1'b0;
        #1;
        chk("arst_oe", 128'(cmd_oe_o), 128'd0);
        chk("arst_cmd_o", 128'(cmd_o), 128'd1);
        chk("arst_busy", 128'(busy_o), 128'd0);
        chk("arst_resp", 128'(resp_o), 128'd0);
        step();
        rst_ni = 1'b1;
        exp_resp = '0;
        exp_errs = '0;
        run_cmd("post_arst", 6'd8, 32'h1AA, 2'b10, 1, 1, 0, 6'd8, 5, -1, 0, tx);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
